// File: rtl/digit_scan_mux.sv
// -----------------------------------------------------------------------------
// digit_scan_mux
//
// Time-multiplexed seven-segment display scanner. Walks a digit index across
// NUM_DIGITS slots of PRESCALE clocks each, presents the selected digit code,
// its index and a one-hot anode enable on registered outputs. New digit values
// are captured into a pending buffer on load and moved into the display shadow
// only at the frame boundary, so a frame never shows a mix of old and new
// digits.
//
// Optional feature: define DIGIT_SCAN_LZB_EN to enable leading-zero blanking
// (digit i >= 1 blanked when it and every higher shadow digit are zero).
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   digits_in     packed digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   digit_en      per-digit enable, 0 blanks that digit (used live)
//   load          capture digits_in
//   digit_out     shadow code of the digit in the current slot
//   digit_sel     index of the digit in the current slot
//   anode         one-hot digit enable, active level set by ANODE_ACTIVE_LOW
//   blank         current slot is blanked
//   frame_done    one-cycle pulse when the scan wraps to digit 0
//   load_pending  a captured value waits for the frame boundary
// -----------------------------------------------------------------------------
module digit_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_W          = 4,
  parameter int PRESCALE         = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [SEL_W-1:0]              digit_sel,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic                          blank,
  output logic                          frame_done,
  output logic                          load_pending
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;

  // XOR mask that converts an active-high enable into the pin polarity;
  // it also doubles as the "all digits off" pin pattern.
  localparam logic [NUM_DIGITS-1:0] ANODE_IDLE =
      ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PCNT_W-1:0]     pcnt_r;
  logic [SEL_W-1:0]      idx_r;
  logic [DATA_W-1:0]     pend_r;
  logic [DATA_W-1:0]     shadow_r;
  logic                  load_pending_r;
  logic                  frame_done_r;
  logic [DIGIT_W-1:0]    digit_out_r;
  logic [SEL_W-1:0]      digit_sel_r;
  logic [NUM_DIGITS-1:0] anode_r;
  logic                  blank_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [DIGIT_W-1:0]    cur_digit_s;
  logic [NUM_DIGITS-1:0] onehot_s;
  logic [NUM_DIGITS-1:0] lz_s;
  logic                  slot_blank_s;
  logic [NUM_DIGITS-1:0] anode_next_s;

  assign tick_s = (pcnt_r == PCNT_W'(PRESCALE - 1));
  assign wrap_s = tick_s && (idx_r == SEL_W'(NUM_DIGITS - 1));

  // Prescaler: one tick every PRESCALE clocks (constant tick when PRESCALE=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= {PCNT_W{1'b0}};
    end else if (tick_s) begin
      pcnt_r <= {PCNT_W{1'b0}};
    end else begin
      pcnt_r <= pcnt_r + PCNT_W'(1);
    end
  end

  // Digit index: advances on tick, wraps to 0 after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= {SEL_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (wrap_s) begin
        idx_r <= {SEL_W{1'b0}};
      end else if (tick_s) begin
        idx_r <= idx_r + SEL_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Load path: a load on the wrap edge bypasses pend; otherwise the pending
  // value is promoted to the shadow at the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r         <= {DATA_W{1'b0}};
      shadow_r       <= {DATA_W{1'b0}};
      load_pending_r <= 1'b0;
    end else if (wrap_s) begin
      load_pending_r <= 1'b0;
      if (load) begin
        pend_r   <= digits_in;
        shadow_r <= digits_in;
      end else if (load_pending_r) begin
        shadow_r <= pend_r;
      end else begin
        shadow_r <= shadow_r;
      end
    end else if (load) begin
      pend_r         <= digits_in;
      load_pending_r <= 1'b1;
    end else begin
      pend_r         <= pend_r;
      load_pending_r <= load_pending_r;
    end
  end

  // Slot decode: selected shadow digit and one-hot position of idx.
  always_comb begin
    cur_digit_s = {DIGIT_W{1'b0}};
    onehot_s    = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (idx_r == SEL_W'(i));
      cur_digit_s = onehot_s[i] ? shadow_r[i*DIGIT_W +: DIGIT_W] : cur_digit_s;
    end
  end

`ifdef DIGIT_SCAN_LZB_EN
  logic upper_zero_s;

  // Leading-zero mask: scan from the top digit down while digits stay zero.
  always_comb begin
    lz_s         = {NUM_DIGITS{1'b0}};
    upper_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero_s = upper_zero_s &&
                     (shadow_r[i*DIGIT_W +: DIGIT_W] == {DIGIT_W{1'b0}});
      lz_s[i]      = upper_zero_s;
    end
  end
`else
  assign lz_s = {NUM_DIGITS{1'b0}};
`endif

  assign slot_blank_s = |(onehot_s & (~digit_en | lz_s));
  assign anode_next_s = (slot_blank_s ? {NUM_DIGITS{1'b0}} : onehot_s) ^ ANODE_IDLE;

  // Output registers: sampled every cycle, one cycle behind idx/shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out_r <= {DIGIT_W{1'b0}};
      digit_sel_r <= {SEL_W{1'b0}};
      blank_r     <= 1'b1;
      anode_r     <= ANODE_IDLE;
    end else begin
      digit_out_r <= cur_digit_s;
      digit_sel_r <= idx_r;
      blank_r     <= slot_blank_s;
      anode_r     <= anode_next_s;
    end
  end

  assign digit_out    = digit_out_r;
  assign digit_sel    = digit_sel_r;
  assign anode        = anode_r;
  assign blank        = blank_r;
  assign frame_done   = frame_done_r;
  assign load_pending = load_pending_r;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux (4 digits x 4 bits, PRESCALE 4,
// active-low anodes). A cycle-count based reference model pushes the expected
// outputs at every rising edge; a monitor pops and compares them on the
// falling edge.
module tb_digit_scan_mux;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int P  = 4;
  localparam int FRAME = N * P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   digits_in = 16'h0000;
  logic [3:0]    digit_en = 4'b1111;
  logic          load = 1'b0;
  logic [3:0]    digit_out;
  logic [1:0]    digit_sel;
  logic [3:0]    anode;
  logic          blank;
  logic          frame_done;
  logic          load_pending;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] dout;
    logic [1:0] sel;
    logic [3:0] an;
    logic       blk;
    logic       fd;
    logic       lp;
  } exp_t;

  exp_t exp_q[$];

  // model state
  int          m_k = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_pending = 1'b0;

  digit_scan_mux #(
    .NUM_DIGITS(N), .DIGIT_W(DW), .PRESCALE(P), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digit_en(digit_en),
    .load(load), .digit_out(digit_out), .digit_sel(digit_sel), .anode(anode),
    .blank(blank), .frame_done(frame_done), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: derive slot from the number of edges since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k       = 0;
      m_shadow  = 16'h0000;
      m_pend    = 16'h0000;
      m_pending = 1'b0;
      exp_q.delete();
    end else begin
      exp_t e;
      int   idx;
      logic wrap;
      logic blk;
      idx  = (m_k / P) % N;
      wrap = (((m_k + 1) % FRAME) == 0);
      blk  = !digit_en[idx];
`ifdef DIGIT_SCAN_LZB_EN
      if (idx >= 1 && ((m_shadow >> (idx * DW)) == 16'h0000)) blk = 1'b1;
`endif
      e.dout = 4'((m_shadow >> (idx * DW)) & 16'h000F);
      e.sel  = 2'(idx);
      e.an   = blk ? 4'b1111 : ~(4'b0001 << idx);
      e.blk  = blk;
      e.fd   = wrap;
      if (wrap) begin
        if (load) m_shadow = digits_in;
        else if (m_pending) m_shadow = m_pend;
        m_pending = 1'b0;
      end else if (load) begin
        m_pend    = digits_in;
        m_pending = 1'b1;
      end
      e.lp = m_pending;
      exp_q.push_back(e);
      m_k++;
    end
  end

  // Monitor: compare DUT outputs half a cycle after each edge.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val("digit_out",    32'(digit_out),    32'(e.dout));
      check_val("digit_sel",    32'(digit_sel),    32'(e.sel));
      check_val("anode",        32'(anode),        32'(e.an));
      check_val("blank",        32'(blank),        32'(e.blk));
      check_val("frame_done",   32'(frame_done),   32'(e.fd));
      check_val("load_pending", 32'(load_pending), 32'(e.lp));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a negedge where the next rising edge is frame position p.
  task automatic wait_pos(input int p);
    bit found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if ((m_k % FRAME) == p) found = 1'b1;
    end
    check_val("wait_pos_timeout", 32'(found), 32'd1);
  endtask

  task automatic load_at(input int p, input logic [15:0] v);
    wait_pos(p);
    digits_in = v;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_digit_out"},    32'(digit_out),    32'd0);
    check_val({tag, "_digit_sel"},    32'(digit_sel),    32'd0);
    check_val({tag, "_anode"},        32'(anode),        32'hF);
    check_val({tag, "_blank"},        32'(blank),        32'd1);
    check_val({tag, "_frame_done"},   32'(frame_done),   32'd0);
    check_val({tag, "_load_pending"}, 32'(load_pending), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    run(3);
    check_reset_outputs("rst");
    #2 rst_n = 1'b1;
    run(2 * FRAME);

    // mid-frame load of 0x4321, shown after the wrap
    load_at(6, 16'h4321);
    run(2 * FRAME);

    // two loads in one frame, last one wins
    load_at(3, 16'h1111);
    load_at(8, 16'h2222);
    run(FRAME + 4);

    // load exactly on the wrap edge
    load_at(15, 16'h5555);
    run(FRAME);

    // per-digit blanking of digit 2
    digit_en = 4'b1011;
    run(FRAME + 2);
    digit_en = 4'b1111;
    run(2);

    // leading-zero patterns
    load_at(15, 16'h0070);
    run(FRAME);
    load_at(15, 16'h0000);
    run(FRAME);
    load_at(15, 16'h0305);
    run(FRAME);

    // random loads and enables
    for (int r = 0; r < 4; r++) begin
      digit_en = 4'($urandom_range(0, 15));
      load_at(int'($urandom_range(0, FRAME - 1)), 16'($urandom_range(0, 16'hFFFF)));
      run(FRAME + 3);
    end
    digit_en = 4'b1111;

    // reset mid-frame with a load pending at idx 2
    load_at(8, 16'h9999);
    check_val("pending_before_rst", 32'(load_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(FRAME + 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexed display scanner that drives a common-anode/cathode multi-digit seven-segment display from a packed digit vector. It supersedes the static 4-way digit selector: it is parametrised in digit count and digit width, and it generates its own refresh timing and one-hot anode enables. Frame-synchronous shadow loading keeps the display from tearing, and per-digit blanking is supported. It sits between the calculator datapath, which supplies the digit values, and the segment decoder and anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥2)
- DIGIT_W, 4, bits per digit code
- PRESCALE, 50000, clk cycles per digit slot (≥1)
- ANODE_ACTIVE_LOW, 1, 1: active anode driven 0; 0: active anode driven 1
- SEL_W (localparam), max(1, $clog2(NUM_DIGITS)), width of digit_sel

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- digits_in  in  NUM_DIGITS*DIGIT_W  packed digits; digit i occupies bits [i*DIGIT_W +: DIGIT_W]; digit 0 is least significant and rightmost
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit; sampled live, not shadowed
- load  in  1  request to capture digits_in
- digit_out  out  DIGIT_W  code of the currently displayed digit (registered)
- digit_sel  out  SEL_W  index of the currently displayed digit (registered)
- anode  out  NUM_DIGITS  one-hot digit enable, polarity per ANODE_ACTIVE_LOW (registered)
- blank  out  1  1 when the current slot is blanked (registered)
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0
- load_pending  out  1  a captured value is waiting for the frame boundary

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps; `tick` = (pcnt == PRESCALE-1). With PRESCALE=1, tick is constant 1.
- Index `idx` advances by 1 on tick and wraps from NUM_DIGITS-1 to 0. On the wrap edge, frame_done is 1 for that one cycle.
- Load path: when load=1, digits_in is captured into `pend` and load_pending is set.
- At the wrap edge, if load_pending=1, then shadow ← pend and load_pending clears.
- If load=1 on the wrap edge itself, digits_in goes directly to shadow and load_pending stays 0.
- Repeated loads within a frame overwrite pend. The last one wins.
- Slot blank = !digit_en[idx], OR'd with leading-zero blanking (see Configuration).
- Output registers sample every cycle:
  - digit_out ← shadow digit idx
  - digit_sel ← idx
  - blank ← slot blank
  - anode ← one-hot(idx), or all-inactive if blank, then inverted when ANODE_ACTIVE_LOW=1
- digit_out carries the shadow value even when blanked.
- Reset values: pcnt=0, idx=0, pend=0, shadow=0, load_pending=0, frame_done=0, digit_out=0, digit_sel=0, blank=1, anode all inactive (all 1s when ANODE_ACTIVE_LOW=1).
- Asserting rst_n low mid-frame clears everything immediately. A pending load is discarded.

## Timing
- Outputs lag idx and shadow by exactly 1 cycle.
- After rst_n releases, the first edge shows digit 0. Each slot then lasts exactly PRESCALE cycles.
- A frame lasts NUM_DIGITS*PRESCALE cycles. frame_done pulses once per frame, coincident with idx becoming 0.
- Load-to-display latency:
  - Load on the wrap edge: the new value is visible 1 cycle later.
  - Otherwise: it appears 1 cycle after the next wrap edge.
- digit_en changes take effect 1 cycle after sampling, with no frame alignment.
- No combinational path from any input to any output.

## Configuration
- DIGIT_SCAN_LZB_EN defined: leading-zero blanking is enabled.
  - A digit i ≥ 1 is blanked when it and every digit above it in the shadow equal 0.
  - Digit 0 is never blanked by this rule.
  - The result is OR'd with the digit_en blanking.
- DIGIT_SCAN_LZB_EN undefined: only digit_en blanks. Zero digits display normally.

## Test plan
- Reset/scan: PRESCALE=4, NUM_DIGITS=4, all digit_en=1. Release reset → anode=1110, 1101, 1011, 0111, each held 4 cycles. frame_done pulses every 16 cycles as digit_sel returns to 0.
- Shadow timing: load=1 for one cycle mid-frame with digits_in=0x4321 → load_pending=1 and digit_out unchanged until the wrap. After the wrap, digit_out sequence is 1, 2, 3, 4 and load_pending=0.
- Wrap-edge load plus overwrite:
  - Load 0x1111, then 0x2222 in the same frame → only 2s are shown next frame.
  - Load 0x5555 exactly on the wrap edge → 5s appear 1 cycle later with no pending.
- Blanking: digit_en=1011 → slot 2 shows blank=1 and anode=1111. The other slots are unaffected.
- LZB (macro defined): shadow 0x0070 → digits 3 and 2 blanked; digit 1 shows 7; digit 0 shows 0. Shadow 0x0000 → only digit 0 is lit. With the macro undefined, all four digits are lit.
- Reset mid-operation: assert rst_n low with load_pending=1 at idx=2 → outputs go to reset values immediately. After release, the scan restarts at digit 0 showing 0s.
